parking_occupancy_ctrl: RTL
===========================

// Module: parking_occupancy_ctrl
// PURPOSE
//   Downstream consumer of the synchronised one-cycle entry/exit pulses from the sensor pulse stage.
//   Tracks parking-lot occupancy, raises full/empty flags and flags refused entries and bad exits.
//   Drives a timed gate-open request.
//   Sits between the two pulse stages (entry, exit) and the display/gate-drive logic.
// PARAMETERS
//   CAPACITY     9   number of spaces; legal range 1..(2**CNT_W)-1
//   CNT_W        4   occupancy counter width
//   GATE_CYCLES  50  NewCLK cycles the gate stays open after the last accepted entry; must be >=1
//   TMR_W        8   gate timer width; GATE_CYCLES <= (2**TMR_W)-1
// PORTS
//   NewCLK     in   1      system clock; all state updates on its rising edge
//   RST        in   1      asynchronous, active-low reset
//   entry_p    in   1      one-cycle entry pulse (already synchronised, edge-detected)
//   exit_p     in   1      one-cycle exit pulse (already synchronised, edge-detected)
//   count      out  CNT_W  current occupancy, registered
//   full       out  1      count == CAPACITY, registered
//   empty      out  1      count == 0, registered
//   gate_open  out  1      gate-open request, registered
//   reject     out  1      one-cycle pulse: entry refused because the lot is full
//   err_exit   out  1      one-cycle pulse: exit seen while empty (sensor fault)
//   count_bcd  out  8      {tens,units} BCD of count; present only with PARK_BCD_EN
// BEHAVIOUR
//   Reset (RST=0, async): count=0, empty=1, full=0, gate_open=0, reject=0, err_exit=0, timer=0.
//     FSM goes to IDLE; count_bcd=8'h00.
//   All outputs are registered; each reflects the pulse sampled on the preceding NewCLK edge.
//   Latency is 1 cycle.
//   Per edge, with e=entry_p and x=exit_p:
//     e=1,x=0, !full  -> count+1, entry accepted
//     e=1,x=0,  full  -> count held, reject=1 for 1 cycle, gate not opened
//     e=0,x=1, !empty -> count-1
//     e=0,x=1,  empty -> count held at 0, err_exit=1 for 1 cycle
//     e=1,x=1         -> count held, entry accepted, no reject/err_exit, at any count
//       (net-zero swap; legal at full and at empty)
//   The count never wraps: no increment past CAPACITY, no decrement below 0.
//   full and empty are recomputed from the next count value, so they are valid in the same cycle as count.
//   Gate FSM (2 states):
//     IDLE: gate_open=0.
//       Accepted entry -> OPEN, timer=GATE_CYCLES-1.
//     OPEN: gate_open=1.
//       Accepted entry -> timer reloads to GATE_CYCLES-1 and the FSM stays in OPEN.
//       Otherwise, if timer!=0, timer-1.
//       If timer==0 and no accepted entry -> IDLE.
//     An accepted entry holds gate_open high for exactly GATE_CYCLES cycles after its edge.
//     Exits do not affect the gate; a rejected entry neither opens nor extends it.
//   Reset mid-operation: all state clears immediately (asynchronous).
//     The gate closes and occupancy is lost; the first edge after release samples inputs normally.
//   Inputs are assumed single-cycle pulses; a held-high input counts once per cycle it is high.
//     The upstream stage guarantees pulses.
// CONFIGURATION
//   PARK_BCD_EN defined: adds the count_bcd port.
//     count_bcd is registered BCD of the next count, updated in the same cycle as count.
//     Requires CAPACITY <= 99; tens = count/10, units = count%10.
//   PARK_BCD_EN undefined: the count_bcd port and its logic are absent; all other behaviour is identical.
// TESTING
//   1. Reset, then 3 entry_p pulses spaced 5 cycles -> count 1,2,3; empty falls after the 1st.
//      gate_open stays high until GATE_CYCLES after the 3rd pulse.
//   2. CAPACITY=9: 9 entries, then a 10th -> count=9, full=1, reject=1 for exactly 1 cycle.
//      count stays 9; the gate is not re-extended by the 10th.
//   3. Empty lot, exit_p pulse -> err_exit=1 for 1 cycle; count=0, empty=1.
//   4. Simultaneous entry_p & exit_p at count=9 (full) -> count=9, reject=0, gate_open rises.
//      Same at count=0 -> count=0, err_exit=0.
//   5. GATE_CYCLES=50: entry at t0 -> gate_open high t0+1..t0+50, low at t0+51.
//      A 2nd entry at t0+30 -> gate_open low at t0+81.
//   6. Count=7, gate open, RST pulsed low mid-cycle -> count=0, empty=1, gate_open=0 at once.
//      With PARK_BCD_EN: count_bcd=8'h00; after 12 entries with CAPACITY=15, count_bcd=8'h12.

Source files
------------

// File: rtl/parking_occupancy_ctrl_if.sv
// Entry/exit pulse inputs and occupancy/gate status outputs of the parking controller.
// Optional count_bcd signal is present only when PARK_BCD_EN is defined.
interface parking_occupancy_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             entry_p;
    logic             exit_p;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             gate_open;
    logic             reject;
    logic             err_exit;
`ifdef PARK_BCD_EN
    logic [7:0]       count_bcd;
`endif

    // Pulse-stage side: drives pulses, observes status
    modport master (
`ifdef PARK_BCD_EN
        input  count_bcd,
`endif
        output entry_p, exit_p,
        input  count, full, empty, gate_open, reject, err_exit
    );

    // Controller side
    modport slave (
`ifdef PARK_BCD_EN
        output count_bcd,
`endif
        input  entry_p, exit_p,
        output count, full, empty, gate_open, reject, err_exit
    );
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// Parking-lot occupancy tracker with full/empty flags, refused-entry/bad-exit pulses and a timed gate.
// Define PARK_BCD_EN to add a registered BCD copy of the occupancy count.
module parking_occupancy_ctrl #(
    parameter int unsigned CAPACITY    = 9,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned GATE_CYCLES = 50,
    parameter int unsigned TMR_W       = 8
) (
    input  logic                     NewCLK,
    input  logic                     RST,
    parking_occupancy_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] RELOAD_V = TMR_W'(GATE_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OPEN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             reject_q, reject_d;
    logic             err_exit_q, err_exit_d;
    logic             gate_open_q, gate_open_d;
    logic             entry_acc_c;

    // Occupancy update; a simultaneous entry+exit is a net-zero swap that still admits a car
    always_comb begin
        count_d     = count_q;
        reject_d    = 1'b0;
        err_exit_d  = 1'b0;
        entry_acc_c = 1'b0;
        case ({bus.entry_p, bus.exit_p})
            2'b11: entry_acc_c = 1'b1;
            2'b10: begin
                if (full_q) begin
                    reject_d = 1'b1;
                end else begin
                    count_d     = count_q + CNT_W'(1);
                    entry_acc_c = 1'b1;
                end
            end
            2'b01: begin
                if (empty_q) begin
                    err_exit_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
        full_d  = (count_d == CAP_V);
        empty_d = (count_d == '0);
    end

    // Gate FSM: state register
    always_ff @(posedge NewCLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Gate FSM: next state; every accepted entry restarts the hold window
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (entry_acc_c) begin
                    state_d = S_OPEN;
                    timer_d = RELOAD_V;
                end
            end
            S_OPEN: begin
                if (entry_acc_c) begin
                    timer_d = RELOAD_V;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TMR_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Gate FSM: output, decoded from the next state so it lands in the same cycle as the state
    always_comb begin
        gate_open_d = (state_d == S_OPEN);
    end

    always_ff @(posedge NewCLK or negedge RST) begin
        if (!RST) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            reject_q    <= 1'b0;
            err_exit_q  <= 1'b0;
            gate_open_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            reject_q    <= reject_d;
            err_exit_q  <= err_exit_d;
            gate_open_q <= gate_open_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.reject    = reject_q;
    assign bus.err_exit  = err_exit_q;
    assign bus.gate_open = gate_open_q;

`ifdef PARK_BCD_EN
    logic [7:0] count_bcd_q, count_bcd_d;

    always_comb begin
        count_bcd_d = {4'(32'(count_d) / 32'd10), 4'(32'(count_d) % 32'd10)};
    end

    always_ff @(posedge NewCLK or negedge RST) begin
        if (!RST) begin
            count_bcd_q <= 8'h00;
        end else begin
            count_bcd_q <= count_bcd_d;
        end
    end

    assign bus.count_bcd = count_bcd_q;
`endif

endmodule
